rx_frame_commit_ctrl: RTL and testbench



---
 rtl/rx_frame_commit_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_rx_frame_commit_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_commit_ctrl.sv
// Store-and-forward RX frame buffer: bytes are written speculatively, then committed
// or rewound at end of frame; committed frames stream out on a valid/ready byte port.
module rx_frame_commit_ctrl #(
    parameter int ADDR_W          = 11,
    parameter int LENQ_ADDR_W     = 3,
    parameter int MIN_FRAME_BYTES = 64,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data_i,
    input  logic             is_preamble_or_sfd_i,
    input  logic             is_dst_mac_i,
    input  logic             is_src_mac_i,
    input  logic             is_ether_type_i,
    input  logic             is_payload_or_crc_i,
    input  logic             invalid_frame_i,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    output logic             m_last_o,
    input  logic             m_ready_i,
    output logic [CNT_W-1:0] frame_count_o,
    output logic [CNT_W-1:0] drop_count_o
);
    localparam int PTR_W    = ADDR_W + 1;
    localparam int LQC_W    = LENQ_ADDR_W + 1;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int LQ_DEPTH = 1 << LENQ_ADDR_W;
    localparam logic [PTR_W-1:0] BUF_BYTES = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] MIN_LEN   = PTR_W'(MIN_FRAME_BYTES);
    localparam logic [LQC_W-1:0] LQ_FULL   = LQC_W'(LQ_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DISCARD} w_state_t;
    typedef enum logic {R_IDLE, R_STREAM} r_state_t;

    // Output handshake: a byte transfers on a rising edge where m_valid_o & m_ready_i;
    // m_data_o/m_last_o hold while m_valid_o & ~m_ready_i.

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] lenq [LQ_DEPTH];

    w_state_t         w_state_q, w_state_d;
    r_state_t         r_state_q, r_state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_commit_ptr_q, wr_commit_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, len_q, len_d, remain_q, remain_d;
    logic             bad_q, bad_d, rx_active_q, m_last_q, m_last_d;
    logic [7:0]       m_data_q;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
    logic [LENQ_ADDR_W-1:0] lq_wp_q, lq_rp_q;
    logic [LQC_W-1:0] lq_count_q;

    logic rx_active, rx_start, end_cycle, buf_full, lenq_full, lenq_empty;
    logic wr_en, push, pop, commit, drop, bad_upd, load_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [PTR_W-1:0]  lenq_head, rd_next;
    logic preamble_unused;

    assign preamble_unused = is_preamble_or_sfd_i;
    assign rx_active  = is_dst_mac_i | is_src_mac_i | is_ether_type_i | is_payload_or_crc_i;
    // rx_active_q comes out of reset high so the tail of a frame cut by reset is never captured.
    assign rx_start   = rx_active & ~rx_active_q;
    assign end_cycle  = rx_active_q & ~rx_active;
    assign buf_full   = (wr_ptr_q - rd_ptr_q) == BUF_BYTES;
    assign lenq_full  = lq_count_q == LQ_FULL;
    assign lenq_empty = lq_count_q == '0;
    assign lenq_head  = lenq[lq_rp_q];
    assign bad_upd    = bad_q | invalid_frame_i;
    assign rd_next    = rd_ptr_q + PTR_W'(1);

    always_comb begin
        w_state_d       = w_state_q;
        wr_ptr_d        = wr_ptr_q;
        wr_commit_ptr_d = wr_commit_ptr_q;
        len_d           = len_q;
        bad_d           = bad_q;
        wr_en           = 1'b0;
        commit          = 1'b0;
        drop            = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (rx_start) begin
                    if (buf_full) begin
                        w_state_d = W_DISCARD;
                    end else begin
                        wr_en     = 1'b1;
                        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                        len_d     = PTR_W'(1);
                        bad_d     = invalid_frame_i;
                        w_state_d = W_WRITE;
                    end
                end
            end
            W_WRITE: begin
                bad_d = bad_upd;
                if (end_cycle) begin
                    if (!bad_upd && len_q >= MIN_LEN && !lenq_full) commit = 1'b1;
                    else drop = 1'b1;
                    w_state_d = W_IDLE;
                end else if (rx_active) begin
                    if (buf_full) begin
                        w_state_d = W_DISCARD;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        if (len_q != BUF_BYTES) len_d = len_q + PTR_W'(1);
                    end
                end
            end
            W_DISCARD: begin
                if (end_cycle) begin
                    drop      = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (commit) wr_commit_ptr_d = wr_ptr_q;
        if (drop)   wr_ptr_d        = wr_commit_ptr_q;
    end

    assign push        = commit;
    assign frame_cnt_d = (commit && frame_cnt_q != CNT_MAX) ? frame_cnt_q + CNT_W'(1) : frame_cnt_q;
    assign drop_cnt_d  = (drop && drop_cnt_q != CNT_MAX) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;

    // The head length stays queued until its last byte is accepted, so the queue
    // counts every committed frame not yet fully delivered.
    always_comb begin
        r_state_d = r_state_q;
        rd_ptr_d  = rd_ptr_q;
        remain_d  = remain_q;
        m_last_d  = m_last_q;
        pop       = 1'b0;
        load_data = 1'b0;
        rd_addr   = rd_ptr_q[ADDR_W-1:0];
        case (r_state_q)
            R_IDLE: begin
                if (!lenq_empty) begin
                    remain_d  = lenq_head;
                    m_last_d  = lenq_head == PTR_W'(1);
                    load_data = 1'b1;
                    r_state_d = R_STREAM;
                end
            end
            R_STREAM: begin
                if (m_ready_i) begin
                    rd_ptr_d = rd_next;
                    if (m_last_q) begin
                        pop       = 1'b1;
                        m_last_d  = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        remain_d  = remain_q - PTR_W'(1);
                        m_last_d  = remain_q == PTR_W'(2);
                        load_data = 1'b1;
                        rd_addr   = rd_next[ADDR_W-1:0];
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= rx_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q       <= W_IDLE;
            r_state_q       <= R_IDLE;
            wr_ptr_q        <= '0;
            wr_commit_ptr_q <= '0;
            rd_ptr_q        <= '0;
            len_q           <= '0;
            remain_q        <= '0;
            bad_q           <= 1'b0;
            rx_active_q     <= 1'b1;
            m_last_q        <= 1'b0;
            m_data_q        <= '0;
            frame_cnt_q     <= '0;
            drop_cnt_q      <= '0;
            lq_wp_q         <= '0;
            lq_rp_q         <= '0;
            lq_count_q      <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) lenq[i] <= '0;
        end else begin
            w_state_q       <= w_state_d;
            r_state_q       <= r_state_d;
            wr_ptr_q        <= wr_ptr_d;
            wr_commit_ptr_q <= wr_commit_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            len_q           <= len_d;
            remain_q        <= remain_d;
            bad_q           <= bad_d;
            rx_active_q     <= rx_active;
            m_last_q        <= m_last_d;
            frame_cnt_q     <= frame_cnt_d;
            drop_cnt_q      <= drop_cnt_d;
            if (load_data) m_data_q <= mem[rd_addr];
            if (push) begin
                lenq[lq_wp_q] <= len_q;
                lq_wp_q       <= lq_wp_q + LENQ_ADDR_W'(1);
            end
            if (pop) lq_rp_q <= lq_rp_q + LENQ_ADDR_W'(1);
            if (push && !pop) lq_count_q <= lq_count_q + LQC_W'(1);
            else if (pop && !push) lq_count_q <= lq_count_q - LQC_W'(1);
        end
    end

    assign m_valid_o     = r_state_q == R_STREAM;
    assign m_data_o      = m_data_q;
    assign m_last_o      = m_last_q;
    assign frame_count_o = frame_cnt_q;
    assign drop_count_o  = drop_cnt_q;
endmodule

// File: tb/tb_rx_frame_commit_ctrl.sv
// Directed bench for rx_frame_commit_ctrl with a small buffer (256 B) and a 2-entry
// length queue so overflow and queue-full drops are reachable quickly.
module tb_rx_frame_commit_ctrl;
    localparam int ADDR_W = 8;
    localparam int LQ_W   = 1;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rx_data_i;
    logic             is_preamble_or_sfd_i, is_dst_mac_i, is_src_mac_i;
    logic             is_ether_type_i, is_payload_or_crc_i, invalid_frame_i;
    logic [7:0]       m_data_o;
    logic             m_valid_o, m_last_o, m_ready_i;
    logic [CNT_W-1:0] frame_count_o, drop_count_o;

    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [8:0] prev_word  = '0;

    rx_frame_commit_ctrl #(
        .ADDR_W(ADDR_W), .LENQ_ADDR_W(LQ_W), .MIN_FRAME_BYTES(64), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .rx_data_i(rx_data_i),
        .is_preamble_or_sfd_i(is_preamble_or_sfd_i), .is_dst_mac_i(is_dst_mac_i),
        .is_src_mac_i(is_src_mac_i), .is_ether_type_i(is_ether_type_i),
        .is_payload_or_crc_i(is_payload_or_crc_i), .invalid_frame_i(invalid_frame_i),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
        .m_ready_i(m_ready_i), .frame_count_o(frame_count_o), .drop_count_o(drop_count_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every accepted byte must match the head of exp_q ({last,data})
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid_o), 32'd1);
                check("stall_hold", 32'({m_last_o, m_data_o}), 32'(prev_word));
            end
            if (m_valid_o && m_ready_i) begin
                logic [9:0] exp_word;
                exp_word = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 10'h200;
                check("out_byte", 32'({1'b0, m_last_o, m_data_o}), 32'(exp_word));
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_word  = {m_last_o, m_data_o};
        end
    end

    // driver tasks
    task automatic drive_byte(input logic [7:0] d, input logic pre, input logic dst,
                              input logic src, input logic typ, input logic pay,
                              input logic inv);
        @(posedge clk);
        #1;
        rx_data_i            = d;
        is_preamble_or_sfd_i = pre;
        is_dst_mac_i         = dst;
        is_src_mac_i         = src;
        is_ether_type_i      = typ;
        is_payload_or_crc_i  = pay;
        invalid_frame_i      = inv;
    endtask

    task automatic clear_inputs();
        rx_data_i            = '0;
        is_preamble_or_sfd_i = 1'b0;
        is_dst_mac_i         = 1'b0;
        is_src_mac_i         = 1'b0;
        is_ether_type_i      = 1'b0;
        is_payload_or_crc_i  = 1'b0;
        invalid_frame_i      = 1'b0;
    endtask

    task automatic send_bytes(input int n, input int bad_at, input logic [7:0] base);
        for (int i = 0; i < 8; i++) drive_byte((i == 7) ? 8'hD5 : 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = base + 8'(i);
            drive_byte(d, 1'b0, i < 6, i >= 6 && i < 12, i >= 12 && i < 14, i >= 14, i == bad_at);
        end
    endtask

    // Returns during cycle E+1 (one cycle after the end cycle).
    task automatic send_frame(input int n, input int bad_at, input logic bad_end,
                              input logic [7:0] base, input logic expect_commit);
        if (expect_commit) begin
            for (int i = 0; i < n; i++) begin
                logic [7:0] d;
                d = base + 8'(i);
                exp_q.push_back({i == n - 1, d});
            end
        end
        send_bytes(n, bad_at, base);
        drive_byte(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bad_end);
        drive_byte(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || m_valid_o); i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic drain_random(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || m_valid_o); i++) begin
            @(posedge clk);
            #1 m_ready_i = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1 m_ready_i = 1'b1;
        check("drain_rand", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(m_valid_o), 32'd0);
        check({tag, "_last"},  32'(m_last_o),  32'd0);
        check({tag, "_data"},  32'(m_data_o),  32'd0);
        check({tag, "_frames"}, 32'(frame_count_o), 32'd0);
        check({tag, "_drops"},  32'(drop_count_o),  32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        m_ready_i = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // good 64-byte frame, first byte at E+2
        m_ready_i = 1'b1;
        send_frame(64, -1, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("lat_e1_valid", 32'(m_valid_o), 32'd0);
        @(negedge clk);
        check("lat_e2_valid", 32'(m_valid_o), 32'd1);
        check("lat_e2_data", 32'(m_data_o), 32'h00);
        wait_drain(200);
        check("frames_1", 32'(frame_count_o), 32'd1);

        // invalid mid-frame and on the end cycle
        send_frame(64, 20, 1'b0, 8'h00, 1'b0);
        send_frame(64, -1, 1'b1, 8'h00, 1'b0);
        check("drops_2", 32'(drop_count_o), 32'd2);
        send_frame(64, -1, 1'b0, 8'h40, 1'b1);
        wait_drain(200);
        check("frames_2", 32'(frame_count_o), 32'd2);

        // runt then good
        send_frame(63, -1, 1'b0, 8'h00, 1'b0);
        check("drops_runt", 32'(drop_count_o), 32'd3);
        send_frame(64, -1, 1'b0, 8'h80, 1'b1);
        wait_drain(200);
        check("frames_3", 32'(frame_count_o), 32'd3);

        // buffer overflow with output stalled: 200 committed, 60 overflows
        m_ready_i = 1'b0;
        send_frame(200, -1, 1'b0, 8'h10, 1'b1);
        check("frames_4", 32'(frame_count_o), 32'd4);
        send_frame(60, -1, 1'b0, 8'hC0, 1'b0);
        check("drops_ovf", 32'(drop_count_o), 32'd4);
        @(negedge clk);
        check("stalled_valid", 32'(m_valid_o), 32'd1);
        check("stalled_data", 32'(m_data_o), 32'h10);
        @(posedge clk);
        #1 m_ready_i = 1'b1;
        wait_drain(400);
        send_frame(64, -1, 1'b0, 8'h05, 1'b1);
        wait_drain(200);
        check("frames_5", 32'(frame_count_o), 32'd5);

        // length queue full: third frame dropped, then random backpressure
        m_ready_i = 1'b0;
        send_frame(64, -1, 1'b0, 8'h20, 1'b1);
        send_frame(64, -1, 1'b0, 8'h60, 1'b1);
        send_frame(64, -1, 1'b0, 8'hA0, 1'b0);
        check("frames_7", 32'(frame_count_o), 32'd7);
        check("drops_lq", 32'(drop_count_o), 32'd5);
        drain_random(3000);

        // reset mid-write
        send_bytes(30, -1, 8'h00);
        @(posedge clk);
        #3 rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        check_reset_outputs("rst_wr");
        @(posedge clk);
        #1 rst = 1'b0;

        // reset mid-output
        m_ready_i = 1'b1;
        send_frame(64, -1, 1'b0, 8'h33, 1'b1);
        repeat (10) @(negedge clk);
        check("mid_out_frames", 32'(frame_count_o), 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("rst_out");
        @(posedge clk);
        #1 rst = 1'b0;
        send_frame(64, -1, 1'b0, 8'h77, 1'b1);
        wait_drain(200);
        check("post_rst_frames", 32'(frame_count_o), 32'd1);
        check("post_rst_drops", 32'(drop_count_o), 32'd0);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
